// File: rtl/rd_acc_pkg.sv
// rd_acc_pkg: REGIF accessor constants shared with the write accessor, response layout and FSM states
package rd_acc_pkg;

    localparam logic [31:0] ACK_DEF  = 32'h1;
    localparam logic [31:0] NACK_DEF = 32'h2;
    localparam logic [3:0]  MST_BE   = 4'hF;
    localparam int          STAT_LSB = 32;
    localparam int          DATA_LSB = 0;

    typedef enum logic [7:0] {
        FLUSH    = 8'b0000_0001,
        IDLE     = 8'b0000_0010,
        ARB      = 8'b0000_0100,
        REQ      = 8'b0000_1000,
        XFER     = 8'b0001_0000,
        BUILD    = 8'b0010_0000,
        SEND     = 8'b0100_0000,
        WAIT_ACK = 8'b1000_0000
    } state_t;

    function automatic logic [63:0] pack_resp(input logic [31:0] status, input logic [31:0] data);
        pack_resp = '0;
        pack_resp[STAT_LSB +: 32] = status;
        pack_resp[DATA_LSB +: 32] = data;
    endfunction

endpackage

// File: rtl/rd_acc_if.sv
// rd_acc_if: REGIF master read channel between an accessor (master) and the bus (slave)
interface rd_acc_if;

    logic        IP2Bus_MstRd_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [3:0]  IP2Bus_Mst_BE;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n;
    logic        IP2Bus_MstRd_dst_rdy_n;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstRd_dst_rdy_n,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n
    );

    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE, IP2Bus_MstRd_dst_rdy_n,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n
    );

endinterface

// File: rtl/rd_acc_sync2.sv
// rd_acc_sync2: two-flop synchroniser with synchronous clear
module rd_acc_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, s1} <= 2'b00;
        else     {q, s1} <= clr ? 2'b00 : {s1, d};
    end

endmodule

// File: rtl/rd_acc.sv
// rd_acc: host register-read accessor; wins REGIF, issues one 32-bit master read and
// returns {ACK/NACK, data} to the response path.
module rd_acc
    import rd_acc_pkg::*;
#(
    parameter logic [31:0] ACK_CODE       = ACK_DEF,
    parameter logic [31:0] NACK_CODE      = NACK_DEF,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] acc_addr,
    input  logic        acc_en,
    output logic        acc_en_ack,
    rd_acc_if.master    bus,
    output logic        snd_resp,
    input  logic        snd_resp_ack,
    output logic [63:0] resp,
    input  logic        my_regif,
    output logic        drv_regif
);

    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    logic          en_s, ack_s, clr;
    logic          req, req_n, dst, dst_n, ds, ds_n, cs, cs_n, err, err_n;
    logic          ack_n, snd_n, drv_n;
    logic [31:0]   addr, addr_n, cap, cap_n, data, data_n;
    logic [63:0]   resp_n;
    logic [CW-1:0] cnt, cnt_n;

    rd_acc_sync2 u_en_sync  (.clk(clk), .rst(rst), .clr(clr), .d(acc_en),       .q(en_s));
    rd_acc_sync2 u_ack_sync (.clk(clk), .rst(rst), .clr(clr), .d(snd_resp_ack), .q(ack_s));

    assign bus.IP2Bus_MstRd_Req       = req;
    assign bus.IP2Bus_Mst_Addr        = addr;
    assign bus.IP2Bus_Mst_BE          = MST_BE;
    assign bus.IP2Bus_MstRd_dst_rdy_n = dst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FLUSH;
            acc_en_ack <= 1'b0;
            req        <= 1'b0;
            addr       <= '0;
            cap        <= '0;
            dst        <= 1'b1;
            snd_resp   <= 1'b0;
            resp       <= '0;
            drv_regif  <= 1'b0;
            data       <= '0;
            ds         <= 1'b0;
            cs         <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            acc_en_ack <= ack_n;
            req        <= req_n;
            addr       <= addr_n;
            cap        <= cap_n;
            dst        <= dst_n;
            snd_resp   <= snd_n;
            resp       <= resp_n;
            drv_regif  <= drv_n;
            data       <= data_n;
            ds         <= ds_n;
            cs         <= cs_n;
            err        <= err_n;
            cnt        <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        ack_n   = 1'b0;
        req_n   = req;
        addr_n  = addr;
        cap_n   = cap;
        dst_n   = dst;
        snd_n   = snd_resp;
        resp_n  = resp;
        drv_n   = drv_regif;
        data_n  = data;
        ds_n    = ds;
        cs_n    = cs;
        err_n   = err;
        cnt_n   = cnt;
        case (state)
            FLUSH: begin
                clr     = 1'b1;
                cnt_n   = '0;
                drv_n   = 1'b0;
                addr_n  = '0;
                state_n = IDLE;
            end
            IDLE: begin
                cap_n = acc_addr;
                if (en_s) begin
                    ack_n   = 1'b1;
                    state_n = ARB;
                end
            end
            ARB: if (my_regif) begin
                drv_n   = 1'b1;
                state_n = REQ;
            end
            REQ: begin
                req_n   = 1'b1;
                addr_n  = cap;
                dst_n   = 1'b0;
                ds_n    = 1'b0;
                cs_n    = 1'b0;
                err_n   = 1'b0;
                cnt_n   = cnt + 1'b1;
                state_n = XFER;
            end
            XFER: begin
                // CmdAck, data beat and Cmplt may all land in one cycle, so exit uses the merged flags
                cnt_n = cnt + 1'b1;
                if (bus.Bus2IP_Mst_CmdAck) req_n = 1'b0;
                if (!bus.Bus2IP_MstRd_src_rdy_n) begin
                    data_n = bus.Bus2IP_MstRd_d;
                    ds_n   = 1'b1;
                end
                if (bus.Bus2IP_Mst_Cmplt) begin
                    cs_n  = 1'b1;
                    err_n = bus.Bus2IP_Mst_Error;
                end
                if (cs_n && (ds_n || err_n)) begin
                    req_n   = 1'b0;
                    dst_n   = 1'b1;
                    drv_n   = 1'b0;
                    state_n = BUILD;
                end else if (cnt == LAST) begin
                    req_n   = 1'b0;
                    dst_n   = 1'b1;
                    drv_n   = 1'b0;
                    err_n   = 1'b1;
                    data_n  = '0;
                    state_n = BUILD;
                end
            end
            BUILD: begin
                resp_n  = pack_resp(err ? NACK_CODE : ACK_CODE, err ? 32'h0 : data);
                state_n = SEND;
            end
            SEND: begin
                snd_n   = 1'b1;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: if (ack_s) begin
                snd_n   = 1'b0;
                state_n = FLUSH;
            end
            default: state_n = FLUSH;
        endcase
    end

endmodule

// File: tb/tb_rd_acc.sv
// tb_rd_acc: directed and randomized read transactions checked against a transaction-level model
module tb_rd_acc;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] acc_addr = '0;
    logic        acc_en = 1'b0;
    logic        acc_en_ack;
    logic        snd_resp;
    logic        snd_resp_ack = 1'b0;
    logic [63:0] resp;
    logic        my_regif = 1'b0;
    logic        drv_regif;

    int          checks = 0;
    int          errors = 0;
    logic        mon_on = 1'b0;
    logic [31:0] exp_addr = '0;
    logic [63:0] exp_resp = '0;

    rd_acc_if bus ();

    rd_acc #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .acc_addr(acc_addr), .acc_en(acc_en), .acc_en_ack(acc_en_ack),
        .bus(bus), .snd_resp(snd_resp), .snd_resp_ack(snd_resp_ack), .resp(resp),
        .my_regif(my_regif), .drv_regif(drv_regif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic want);
        chk(name, {63'b0, got}, {63'b0, want});
    endtask

    task automatic chk_reset(input string p);
        chk1({p, "_acc_en_ack"}, acc_en_ack, 1'b0);
        chk1({p, "_req"}, bus.IP2Bus_MstRd_Req, 1'b0);
        chk({p, "_addr"}, 64'(bus.IP2Bus_Mst_Addr), 64'd0);
        chk1({p, "_dst_rdy_n"}, bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
        chk1({p, "_snd_resp"}, snd_resp, 1'b0);
        chk({p, "_resp"}, resp, 64'd0);
        chk1({p, "_drv_regif"}, drv_regif, 1'b0);
    endtask

    task automatic bus_idle();
        bus.Bus2IP_Mst_CmdAck      = 1'b0;
        bus.Bus2IP_Mst_Cmplt       = 1'b0;
        bus.Bus2IP_Mst_Error       = 1'b0;
        bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
        bus.Bus2IP_MstRd_d         = $urandom;
    endtask

    // Per-cycle invariants against the current transaction's expected address and response
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("be", 64'(bus.IP2Bus_Mst_BE), 64'hF);
            if (bus.IP2Bus_MstRd_Req) begin
                chk("req_addr", 64'(bus.IP2Bus_Mst_Addr), 64'(exp_addr));
                chk1("req_implies_drv", drv_regif, 1'b1);
            end
            if (snd_resp) chk("resp_while_valid", resp, exp_resp);
            if (!drv_regif) chk1("dst_rdy_n_when_released", bus.IP2Bus_MstRd_dst_rdy_n, 1'b1);
        end
    end

    // One read: gdly = grant delay, adly/ddly/cdly = CmdAck/data/Cmplt cycle after Req rises
    // (-1 = never), silent = bus never answers, rst_at = XFER cycle to pulse reset (-1 = none)
    task automatic do_read(input logic [31:0] a, input int gdly, input int adly, input int ddly,
                           input int cdly, input logic e, input logic silent, input logic [31:0] dv,
                           input int rst_at, input int hold, output logic [63:0] got,
                           output int drv_cnt);
        int k, td;
        got      = '0;
        drv_cnt  = 0;
        td       = silent ? TO - 2 : (e ? cdly : (ddly > cdly ? ddly : cdly));
        exp_addr = a;
        exp_resp = (e || silent) ? {32'h2, 32'h0} : {32'h1, dv};
        acc_addr = a;
        acc_en   = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!acc_en_ack && k < 10);
        chk("acc_en_ack_latency", 64'(k), 64'd3);
        acc_en   = 1'b0;
        acc_addr = ~a;
        if (!acc_en_ack) return;
        repeat (gdly) begin
            @(negedge clk);
            chk1("no_drv_before_grant", drv_regif, 1'b0);
            chk1("no_req_before_grant", bus.IP2Bus_MstRd_Req, 1'b0);
        end
        my_regif = 1'b1;
        @(negedge clk);
        chk1("acc_en_ack_pulse", acc_en_ack, 1'b0);
        chk1("drv_after_grant", drv_regif, 1'b1);
        chk1("req_after_grant", bus.IP2Bus_MstRd_Req, 1'b0);
        drv_cnt = int'(drv_regif);
        @(negedge clk);
        for (int t = 0; t <= td + 1; t++) begin
            chk1("req", bus.IP2Bus_MstRd_Req, t <= td && (silent || t <= adly));
            chk1("drv_regif", drv_regif, t <= td);
            chk1("dst_rdy_n", bus.IP2Bus_MstRd_dst_rdy_n, t > td);
            drv_cnt += int'(drv_regif);
            if (t == rst_at) begin
                mon_on = 1'b0;
                rst    = 1'b1;
                #1;
                chk_reset("mid_xfer_rst");
                bus_idle();
                my_regif = 1'b0;
                @(negedge clk);
                rst    = 1'b0;
                mon_on = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            bus.Bus2IP_Mst_CmdAck      = !silent && t == adly && t <= td;
            bus.Bus2IP_MstRd_src_rdy_n = !(!silent && t == ddly && t <= td);
            bus.Bus2IP_MstRd_d         = (t == ddly) ? dv : $urandom;
            bus.Bus2IP_Mst_Cmplt       = !silent && t == cdly;
            bus.Bus2IP_Mst_Error       = !silent && e && t == cdly;
            if (t <= td) @(negedge clk);
        end
        k = 0;
        while (!snd_resp && k < 10) begin @(negedge clk); k++; end
        chk("snd_resp_latency", 64'(k), 64'd2);
        got = resp;
        chk("resp", resp, exp_resp);
        repeat (hold) begin
            @(negedge clk);
            chk1("snd_resp_held", snd_resp, 1'b1);
        end
        snd_resp_ack = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (snd_resp && k < 10);
        chk("snd_resp_ack_latency", 64'(k), 64'd3);
        snd_resp_ack = 1'b0;
        my_regif     = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [63:0] got;
        int          dc;
        bus_idle();
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);

        do_read(32'h40, 0, 0, 2, 2, 1'b0, 1'b0, 32'hCAFEF00D, -1, 5, got, dc);
        chk("normal_resp", got, 64'h00000001_CAFEF00D);
        do_read(32'h1000_0004, 1, 0, -1, 1, 1'b1, 1'b0, 32'hDEADBEEF, -1, 0, got, dc);
        chk("bus_error_resp", got, 64'h00000002_00000000);
        do_read(32'h8, 0, 0, 0, 0, 1'b0, 1'b0, 32'h12345678, -1, 1, got, dc);
        chk("same_cycle_resp", got, 64'h00000001_12345678);
        do_read(32'hC, 0, 0, 0, 0, 1'b0, 1'b1, 32'h0, -1, 0, got, dc);
        chk("timeout_resp", got, 64'h00000002_00000000);
        chk("timeout_drv_cycles", 64'(dc), 64'd16);
        do_read(32'h44, 50, 1, 3, 3, 1'b0, 1'b0, 32'hA5A5_0001, -1, 2, got, dc);
        chk("grant_delay_resp", got, 64'h00000001_A5A50001);
        do_read(32'h48, 0, 0, 4, 1, 1'b0, 1'b0, 32'h0BAD_F00D, -1, 0, got, dc);
        chk("data_after_cmplt_resp", got, 64'h00000001_0BADF00D);
        do_read(32'h80, 0, 1, 8, 8, 1'b0, 1'b0, 32'h55AA_55AA, 3, 0, got, dc);
        do_read(32'h84, 0, 0, 1, 1, 1'b0, 1'b0, 32'h0000_BEEF, -1, 0, got, dc);
        chk("after_reset_resp", got, 64'h00000001_0000BEEF);

        repeat (40) begin
            int   c, ad, dd, gd;
            logic e, sil;
            e   = ($urandom_range(0, 3) == 0);
            sil = ($urandom_range(0, 9) == 0);
            c   = int'($urandom_range(0, 8));
            ad  = int'($urandom_range(0, c));
            dd  = (e && $urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 8));
            gd  = int'($urandom_range(0, 5));
            do_read($urandom, gd, ad, dd, c, e, sil, $urandom, -1,
                    int'($urandom_range(0, 4)), got, dc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
